// File: rtl/rv_addsub_pkg.sv
// rv_addsub_pkg: shared types and constants for the pipelined add/sub/compare unit.
//   addsub_op_e   : operation code (ADD, SUB, SLT, SLTU)
//   addsub_ctrl_t : control payload carried alongside the data of every stage
// Optional feature macro: RV_ADDSUB_WOP_EN (adds the RV64 W-op fields).
package rv_addsub_pkg;

  localparam int STAGES_MAX = 4;
  localparam int OP_W       = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } addsub_op_e;

  // Sign bits are captured at entry so the last stage can form the overflow
  // flag without carrying full operands to the end of the pipe.
  typedef struct packed {
    addsub_op_e op;
    logic       a_msb;
    logic       b_msb;
`ifdef RV_ADDSUB_WOP_EN
    logic       word;
    logic       a31;
    logic       b31;
`endif
  } addsub_ctrl_t;

endpackage

// File: rtl/rv_addsub_stage.sv
// rv_addsub_stage: one CHUNK-wide slice of the add/sub pipeline.
//   valid_i/valid_o/ready_i : stage handshake (ready_i = downstream ready)
//   a_rem_i/b_rem_i         : remaining operand bits, current chunk in the LSBs
//   sum_i/zero_i/cin_i      : accumulated partial sum, zero flag, carry in
//   ctrl_i/tag_i            : control payload and sideband tag
//   *_o                     : registered versions for the next stage
// Optional feature macro: RV_ADDSUB_WOP_EN (bit-31 carry and low-word zero).
module rv_addsub_stage
  import rv_addsub_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16,
  parameter int IDX   = 0,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  input  logic               ready_i,
  output logic               valid_o,
  input  logic [XLEN-1:0]    a_rem_i,
  input  logic [XLEN-1:0]    b_rem_i,
  input  logic [XLEN-1:0]    sum_i,
  input  logic               cin_i,
  input  logic               zero_i,
  input  addsub_ctrl_t       ctrl_i,
  input  logic [TAG_W-1:0]   tag_i,
`ifdef RV_ADDSUB_WOP_EN
  input  logic               c31_i,
  input  logic               zero32_i,
  output logic               c31_o,
  output logic               zero32_o,
`endif
  output logic [XLEN-1:0]    a_rem_o,
  output logic [XLEN-1:0]    b_rem_o,
  output logic [XLEN-1:0]    sum_o,
  output logic               cout_o,
  output logic               zero_o,
  output addsub_ctrl_t       ctrl_o,
  output logic [TAG_W-1:0]   tag_o
);

  typedef logic [XLEN-1:0] word_t;

  logic             valid_q;
  logic             stage_ready;
  logic             load;
  logic [CHUNK:0]   add_w;
  logic [CHUNK-1:0] chunk_sum;

  word_t        a_rem_d, a_rem_q, b_rem_d, b_rem_q, sum_d, sum_q;
  logic         carry_d, carry_q, zero_d, zero_q;
  addsub_ctrl_t ctrl_q;
  logic [TAG_W-1:0] tag_q;

  assign add_w     = {1'b0, a_rem_i[CHUNK-1:0]} + {1'b0, b_rem_i[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cin_i};
  assign chunk_sum = add_w[CHUNK-1:0];

  // An empty stage always accepts, which is what collapses bubbles.
  assign stage_ready = ~valid_q | ready_i;
  assign load        = valid_i & stage_ready;

  // Operands shift down one chunk so the next stage always adds its LSBs.
  assign a_rem_d = a_rem_i >> CHUNK;
  assign b_rem_d = b_rem_i >> CHUNK;
  assign sum_d   = sum_i | (word_t'(chunk_sum) << (IDX * CHUNK));
  assign carry_d = add_w[CHUNK];
  assign zero_d  = zero_i & (chunk_sum == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          valid_q <= 1'b0;
    else if (stage_ready) valid_q <= valid_i;
  end

  // NOTE: data registers are reset too, because the outputs must read zero
  // while in reset; afterwards they load only on a stage handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rem_q <= '0;
      b_rem_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ctrl_q  <= '0;
      tag_q   <= '0;
    end else if (load) begin
      a_rem_q <= a_rem_d;
      b_rem_q <= b_rem_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ctrl_q  <= ctrl_i;
      tag_q   <= tag_i;
    end
  end

`ifdef RV_ADDSUB_WOP_EN
  localparam bit IN_LOW32 = (IDX * CHUNK) < 32;
  localparam bit AT_BIT31 = ((IDX + 1) * CHUNK) == 32;

  logic c31_d, c31_q, zero32_d, zero32_q;

  assign c31_d    = AT_BIT31 ? carry_d : c31_i;
  assign zero32_d = zero32_i & (~IN_LOW32 | (chunk_sum == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c31_q    <= 1'b0;
      zero32_q <= 1'b0;
    end else if (load) begin
      c31_q    <= c31_d;
      zero32_q <= zero32_d;
    end
  end

  assign c31_o    = c31_q;
  assign zero32_o = zero32_q;
`endif

  assign valid_o = valid_q;
  assign a_rem_o = a_rem_q;
  assign b_rem_o = b_rem_q;
  assign sum_o   = sum_q;
  assign cout_o  = carry_q;
  assign zero_o  = zero_q;
  assign ctrl_o  = ctrl_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/rv_addsub_pipe.sv
// rv_addsub_pipe: pipelined add/sub/compare unit, one CHUNK per stage.
//   in_valid_i/in_ready_o   : input handshake; op_i, word_i, a_i, b_i, tag_i
//   out_valid_o/out_ready_i : output handshake; res_o, tag_o and flags
//   cout_o, zero_o, ovf_o   : adder carry-out, raw-sum zero, signed overflow
//   eq_o, ltu_o, lts_o      : compare flags (forced 0 for ADD)
// Optional feature macro: RV_ADDSUB_WOP_EN (RV64 W-ops on bits [31:0]).
module rv_addsub_pipe
  import rv_addsub_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             eq_o,
  output logic             ltu_o,
  output logic             lts_o
);

  localparam int CHUNK = XLEN / STAGES;
  typedef logic [XLEN-1:0] word_t;

  if (STAGES < 1 || STAGES > STAGES_MAX || (XLEN % STAGES) != 0) begin : g_bad_cfg
    $error("rv_addsub_pipe: illegal XLEN/STAGES combination");
  end
`ifdef RV_ADDSUB_WOP_EN
  if (XLEN < 32 || (32 % CHUNK) != 0) begin : g_bad_wop
    $error("rv_addsub_pipe: W-ops need XLEN >= 32 and 32 %% CHUNK == 0");
  end
`endif

  // Index k of each array is the input of stage k; index STAGES is the output.
  word_t            a_rem [STAGES+1];
  word_t            b_rem [STAGES+1];
  word_t            sum   [STAGES+1];
  logic             carry [STAGES+1];
  logic             zero  [STAGES+1];
  addsub_ctrl_t     ctrl  [STAGES+1];
  logic [TAG_W-1:0] tag   [STAGES+1];
`ifdef RV_ADDSUB_WOP_EN
  logic             c31    [STAGES+1];
  logic             zero32 [STAGES+1];
  assign c31[0]    = 1'b0;
  assign zero32[0] = 1'b1;
`endif

  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_ready_in;
  logic [STAGES:0]   valid_chain;
  addsub_ctrl_t      ctrl_in;
  logic              is_sub_in;

  assign is_sub_in = addsub_op_e'(op_i) != OP_ADD;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ctrl_in       = '0;
    ctrl_in.op    = addsub_op_e'(op_i);
    ctrl_in.a_msb = a_i[XLEN-1];
    ctrl_in.b_msb = b_i[XLEN-1];
`ifdef RV_ADDSUB_WOP_EN
    ctrl_in.word  = word_i;
    ctrl_in.a31   = a_i[31];
    ctrl_in.b31   = b_i[31];
`endif
  end

  assign a_rem[0] = a_i;
  assign b_rem[0] = is_sub_in ? ~b_i : b_i;
  assign sum[0]   = '0;
  assign carry[0] = is_sub_in;
  assign zero[0]  = 1'b1;
  assign ctrl[0]  = ctrl_in;
  assign tag[0]   = tag_i;

  // Ready ripples back from the output: ready_k = ~valid_k | ready_{k+1}.
  always_comb begin
    logic r;
    r            = out_ready_i;
    stg_ready_in = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stg_ready_in[k] = r;
      r               = ~stg_valid[k] | r;
    end
    in_ready_o = r;
  end

  assign valid_chain = {stg_valid, in_valid_i};
  assign out_valid_o = stg_valid[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rv_addsub_stage #(
      .XLEN (XLEN),
      .CHUNK(CHUNK),
      .IDX  (k),
      .TAG_W(TAG_W)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_chain[k]),
      .ready_i (stg_ready_in[k]),
      .valid_o (stg_valid[k]),
      .a_rem_i (a_rem[k]),
      .b_rem_i (b_rem[k]),
      .sum_i   (sum[k]),
      .cin_i   (carry[k]),
      .zero_i  (zero[k]),
      .ctrl_i  (ctrl[k]),
      .tag_i   (tag[k]),
`ifdef RV_ADDSUB_WOP_EN
      .c31_i   (c31[k]),
      .zero32_i(zero32[k]),
      .c31_o   (c31[k+1]),
      .zero32_o(zero32[k+1]),
`endif
      .a_rem_o (a_rem[k+1]),
      .b_rem_o (b_rem[k+1]),
      .sum_o   (sum[k+1]),
      .cout_o  (carry[k+1]),
      .zero_o  (zero[k+1]),
      .ctrl_o  (ctrl[k+1]),
      .tag_o   (tag[k+1])
    );
  end

  // Flags and result selection from the last stage's registers; outputs
  // therefore hold whenever the last stage does not load.
  always_comb begin
    word_t s_sel;
    logic  c, z, a_m, b_m, s_m, is_add, ovf, lts, ltu;
    s_sel = sum[STAGES];
    c     = carry[STAGES];
    z     = zero[STAGES];
    a_m   = ctrl[STAGES].a_msb;
    b_m   = ctrl[STAGES].b_msb;
    s_m   = sum[STAGES][XLEN-1];
`ifdef RV_ADDSUB_WOP_EN
    if (ctrl[STAGES].word) begin
      s_sel = word_t'($signed(sum[STAGES][31:0]));
      c     = c31[STAGES];
      z     = zero32[STAGES];
      a_m   = ctrl[STAGES].a31;
      b_m   = ctrl[STAGES].b31;
      s_m   = sum[STAGES][31];
    end
`endif
    is_add = ctrl[STAGES].op == OP_ADD;
    ovf    = (is_add ? (a_m == b_m) : (a_m != b_m)) & (a_m != s_m);
    lts    = ~is_add & (s_m ^ ovf);
    ltu    = ~is_add & ~c;

    unique case (ctrl[STAGES].op)
      OP_SLT:  res_o = word_t'(lts);
      OP_SLTU: res_o = word_t'(ltu);
      default: res_o = s_sel;
    endcase
    cout_o = c;
    zero_o = z;
    ovf_o  = ovf;
    eq_o   = ~is_add & z;
    ltu_o  = ltu;
    lts_o  = lts;
  end

  assign tag_o = tag[STAGES];

  // The last stage's remaining-operand registers are always empty by design.
  logic unused_bits;
`ifdef RV_ADDSUB_WOP_EN
  assign unused_bits = ^{a_rem[STAGES], b_rem[STAGES]};
`else
  assign unused_bits = ^{a_rem[STAGES], b_rem[STAGES], word_i};
`endif

endmodule

// File: doc/rv_addsub_pipe.md
# rv_addsub_pipe

Pipelined, parametrised add/sub/compare unit and successor to the single-cycle combinational adder-comparator. Operands are split into `STAGES` equal chunks, and one chunk is added per pipeline stage with the carry registered between stages. The unit has a valid/ready handshake on both sides and bubble-collapsing stalls, and carries a tag alongside each operation. It sits in the execute stage and feeds both ALU writeback and branch resolution.

## Interface
Parameters:
- `XLEN`, default 32: operand width.
- `STAGES`, default 2: pipeline depth, legal range 1..4. `XLEN % STAGES` must be 0. `CHUNK = XLEN/STAGES`.
- `TAG_W`, default 4: width of the sideband tag.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `in_valid_i`  in  1: input operation valid.
- `in_ready_o`  out  1: unit can accept the input.
- `op_i`  in  2: operation code. 00 ADD, 01 SUB, 10 SLT, 11 SLTU.
- `word_i`  in  1: RV64 W-op select (see Configuration).
- `a_i`  in  XLEN: operand A.
- `b_i`  in  XLEN: operand B.
- `tag_i`  in  TAG_W: sideband tag, passed through unchanged.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: consumer accepts the result.
- `res_o`  out  XLEN: result.
- `tag_o`  out  TAG_W: tag of the result.
- `cout_o`  out  1: carry-out of the MSB.
- `zero_o`  out  1: result of the adder is zero.
- `ovf_o`  out  1: signed overflow.
- `eq_o`  out  1: A == B.
- `ltu_o`  out  1: A < B, unsigned.
- `lts_o`  out  1: A < B, signed.

## Operation
Adder configuration:
- SUB, SLT and SLTU use B' = ~B with carry-in 1.
- ADD uses B' = B with carry-in 0.

Per-stage datapath:
- Stage k (0-based) adds chunk k of A and B' plus the registered carry from stage k-1.
- Remaining operand chunks, op, word, tag and sign bits travel down the pipe.
- Each stage accumulates partial sums and a running zero flag (AND of chunk-zero results).

Final-stage flags:
- `cout_o` is the carry out of bit XLEN-1.
- `ovf_o`:
  - ADD: (aMSB == bMSB) & (aMSB != sMSB).
  - SUB/SLT/SLTU: (aMSB != bMSB) & (aMSB != sMSB).
- `eq_o` = zero, `ltu_o` = ~cout, `lts_o` = sMSB ^ ovf. These apply to SUB/SLT/SLTU only.
- For ADD, `eq_o`, `ltu_o` and `lts_o` are forced to 0.

Result selection:
- ADD and SUB: `res_o` = sum.
- SLT: `res_o` = zero-extended `lts`.
- SLTU: `res_o` = zero-extended `ltu`.
- `zero_o` always reflects the raw adder sum, not the selected result.

## Timing
- Latency is exactly `STAGES` cycles from the input handshake (`in_valid_i & in_ready_o`) to `out_valid_o` when there is no backpressure.
- Each stage has its own valid bit. Stage k may load when `ready_k = ~valid_k | ready_{k+1}`, where `ready_STAGES = out_ready_i`. `in_ready_o = ready_0`.
- Bubbles collapse: an empty stage accepts data even while the output is stalled.
- Throughput is 1 operation/cycle while `out_ready_i` = 1.
- Simultaneous output accept and input accept in the same cycle with a full pipe: both happen and there is no lost cycle.
- While `out_valid_o` = 1 and `out_ready_i` = 0, all outputs hold stable.
- Reset, including mid-operation: all valid bits clear asynchronously and every in-flight operation is discarded.
  - Output state during reset: `out_valid_o` = 0, `in_ready_o` = 1, and `res_o`, `tag_o`, `cout_o`, `zero_o`, `ovf_o`, `eq_o`, `ltu_o`, `lts_o` = 0.
- Data registers load only when their stage loads. Outputs are not cleared when a result is consumed, and they are undefined-free because of reset.

## Configuration
- `RV_ADDSUB_WOP_EN` defined:
  - With XLEN = 64 and `word_i` = 1, the unit operates on bits [31:0] only.
  - `res_o` = sign-extension of sum[31].
  - `cout_o`, `ovf_o`, `lts_o`, `ltu_o` and `zero_o`/`eq_o` are taken at bit 31 and bits [31:0].
  - Requires 32 % CHUNK == 0. Elaboration fails otherwise.
- Not defined: `word_i` is ignored and has no logic.

## Structure
- Package `rv_addsub_pkg`:
  - op enum `addsub_op_e` (ADD, SUB, SLT, SLTU).
  - Per-stage payload struct typedef.
  - Constants `STAGES_MAX` = 4 and `OP_W` = 2.
- Sub-module `rv_addsub_stage`: one CHUNK-wide adder, its carry/zero registers and its valid/ready cell, instantiated `STAGES` times in a generate loop.

## Test plan
- Reset mid-stream: XLEN=32, STAGES=2, two operations in flight, assert `rst_ni` = 0 → `out_valid_o` = 0, `in_ready_o` = 1, all outputs 0. After release, the first new result appears exactly 2 cycles after its accept.
- ADD 0xFFFF_FFFF + 1: `res_o` = 0, `cout_o` = 1, `zero_o` = 1, `ovf_o` = 0, `eq_o` = 0. Also ADD 0x7FFF_FFFF + 1: `ovf_o` = 1, `res_o` = 0x8000_0000.
- Compares with a = 0x8000_0000, b = 1:
  - SLT → `res_o` = 1, `lts_o` = 1.
  - SLTU → `res_o` = 0, `ltu_o` = 0.
  - SUB 5 − 5 → `eq_o` = 1, `cout_o` = 1.
- Backpressure: stream tags 0..7 back-to-back, hold `out_ready_i` = 0 for 5 cycles mid-stream → at most STAGES operations are accepted during the stall, outputs hold stable, and tags emerge in order 0..7 with none lost or duplicated.
- Bubble collapse: STAGES=4, a single op stalled at the output with `out_ready_i` = 0 → `in_ready_o` stays 1 until 3 further ops are accepted, then drops.
- With `RV_ADDSUB_WOP_EN`, XLEN=64, `word_i` = 1, ADD 0x0000_0000_7FFF_FFFF + 1 → `res_o` = 0xFFFF_FFFF_8000_0000, `ovf_o` = 1.
